// File: rtl/sm_reg_dump_pkg.sv
// Shared widths, state encoding and output word payload for the debug register scanner.
package sm_reg_dump_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_SEND = 3'd2,
    ST_CSUM = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

endpackage

// File: rtl/sm_reg_dump.sv
// Debug register scanner: walks regAddr over FIRST_REG..LAST_REG and streams each sampled word.
// Define SM_REG_DUMP_CSUM_EN to append a mod-2^32 checksum word after the last register.
module sm_reg_dump
  import sm_reg_dump_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter int unsigned SETTLE    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] regAddr,
  input  logic [DATA_W-1:0] regData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  if (FIRST_REG > LAST_REG || LAST_REG > 31 || SETTLE < 1 || SETTLE > 15) begin : g_param_err
    $error("sm_reg_dump: illegal FIRST_REG/LAST_REG/SETTLE");
  end

  localparam logic [ADDR_W-1:0] FIRST_A     = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A      = ADDR_W'(LAST_REG);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
`ifdef SM_REG_DUMP_CSUM_EN
  localparam logic CSUM_ON = 1'b1;
`else
  localparam logic CSUM_ON = 1'b0;
`endif

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  word_t             word_q, word_d;
`ifdef SM_REG_DUMP_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      word_q  <= '0;
`ifdef SM_REG_DUMP_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      word_q  <= word_d;
`ifdef SM_REG_DUMP_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    word_d  = word_q;
`ifdef SM_REG_DUMP_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          addr_d  = FIRST_A;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ADDR;
`ifdef SM_REG_DUMP_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_ADDR: begin
        cnt_d = cnt + CNT_W'(1);
        if (cnt == SETTLE_LAST) begin
          word_d.addr = addr_q;
          word_d.data = regData;
          word_d.last = (addr_q == LAST_A) && !CSUM_ON;
          valid_d     = 1'b1;
          state_d     = ST_SEND;
`ifdef SM_REG_DUMP_CSUM_EN
          csum_d      = csum_q + regData;
`endif
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (addr_q != LAST_A) begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = '0;
            state_d = ST_ADDR;
          end else begin
`ifdef SM_REG_DUMP_CSUM_EN
            word_d.addr = '0;
            word_d.data = csum_q;
            word_d.last = 1'b1;
            valid_d     = 1'b1;
            state_d     = ST_CSUM;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            addr_d  = '0;
            state_d = ST_FIN;
`endif
          end
        end
      end
`ifdef SM_REG_DUMP_CSUM_EN
      ST_CSUM: begin
        if (out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          addr_d  = '0;
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        // done is high for this single cycle; start is not sampled here
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign regAddr   = addr_q;
  assign out_valid = valid_q;
  assign out_addr  = word_q.addr;
  assign out_data  = word_q.data;
  assign out_last  = word_q.last;

endmodule

// File: tb/tb_sm_reg_dump.sv
// Randomized bench for sm_reg_dump against a list-of-words reference model.
// Honours SM_REG_DUMP_CSUM_EN the same way as the design.
module tb_sm_reg_dump;
  import sm_reg_dump_pkg::*;

  localparam int FIRST    = 0;
  localparam int LAST     = 31;
  localparam int SETTLE_A = 1;
`ifdef SM_REG_DUMP_CSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start, busy, done, out_valid, out_ready, out_last;
  logic [4:0]  regAddr, out_addr;
  logic [31:0] regData, out_data;
  logic        start_b, busy_b, done_b, out_valid_b, out_ready_b, out_last_b;
  logic [4:0]  regAddr_b, out_addr_b;
  logic [31:0] regData_b, out_data_b;

  logic [31:0] rf [32];
  logic [31:0] pc;
  int          checks   = 0;
  int          failures = 0;
  word_t       exp_q[$];

  always #5 clk = ~clk;

  assign regData   = (regAddr == 5'd0) ? pc : rf[regAddr];
  assign regData_b = (regAddr_b == 5'd0) ? pc : rf[regAddr_b];

  sm_reg_dump dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .regAddr(regAddr), .regData(regData), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  sm_reg_dump #(.FIRST_REG(4), .LAST_REG(4), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .regAddr(regAddr_b), .regData(regData_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_addr(out_addr_b), .out_data(out_data_b), .out_last(out_last_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int k);
    return (k == 0) ? pc : rf[k];
  endfunction

  // Expected stream: one word per register, optional checksum word at the end
  function automatic void build_expect(input int first, input int last);
    logic [31:0] sum;
    word_t       w;
    sum = '0;
    exp_q.delete();
    for (int k = first; k <= last; k++) begin
      w.addr = 5'(k);
      w.data = rd(k);
      w.last = (k == last) && (CSUM == 0);
      exp_q.push_back(w);
      sum = sum + rd(k);
    end
    if (CSUM != 0) begin
      w.addr = 5'd0;
      w.data = sum;
      w.last = 1'b1;
      exp_q.push_back(w);
    end
  endfunction

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles on word 2
  task automatic run_scan(input int mode, input int restart_idx, input int abort_idx,
                          input bit poke_fin, input bit check_timing);
    int          words;
    int          n_exp;
    int          done_cyc;
    int          stall_cnt;
    bit          hold;
    bit          rdy;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    logic        h_last;
    word_t       w;
    words = 0; done_cyc = -1; stall_cnt = 0; hold = 1'b0;
    h_addr = '0; h_data = '0; h_last = 1'b0;
    build_expect(FIRST, LAST);
    n_exp = exp_q.size();
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (hold) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_addr", 64'(out_addr), 64'(h_addr));
        check_eq("hold_data", 64'(out_data), 64'(h_data));
        check_eq("hold_last", 64'(out_last), 64'(h_last));
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      if (abort_idx >= 0 && out_valid && words == abort_idx) begin
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_valid", 64'(out_valid), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_regaddr", 64'(regAddr), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("abort_idle_busy", 64'(busy), 64'd0);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(out_valid && words == 2 && stall_cnt < 5);
          if (!rdy) stall_cnt++;
        end
      endcase
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 64'(words + 1), 64'(n_exp));
        end else begin
          w = exp_q.pop_front();
          check_eq("word_addr", 64'(out_addr), 64'(w.addr));
          check_eq("word_data", 64'(out_data), 64'(w.data));
          check_eq("word_last", 64'(out_last), 64'(w.last));
        end
        words++;
        if (words == restart_idx) start = 1'b1;
      end
      hold   = out_valid && !rdy;
      h_addr = out_addr;
      h_data = out_data;
      h_last = out_last;
    end
    check_eq("done_seen", 64'(done_cyc >= 0), 64'd1);
    if (done_cyc < 0) return;
    check_eq("word_count", 64'(words), 64'(n_exp));
    if (check_timing)
      check_eq("done_cycle", 64'(done_cyc), 64'((LAST - FIRST + 1) * (SETTLE_A + 1) + CSUM));
    check_eq("fin_busy", 64'(busy), 64'd0);
    check_eq("fin_regaddr", 64'(regAddr), 64'd0);
    if (poke_fin) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_pulse", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    check_eq("no_requeue_busy", 64'(busy), 64'd0);
    check_eq("no_second_done", 64'(done), 64'd0);
    out_ready = 1'b0;
  endtask

  task automatic run_single;
    int first_valid;
    int words_b;
    bit seen_done;
    first_valid = -1; words_b = 0; seen_done = 1'b0;
    start_b = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      out_ready_b = 1'b1;
      if (done_b) begin
        seen_done = 1'b1;
        break;
      end
      if (out_valid_b) begin
        if (first_valid < 0) begin
          first_valid = c;
          check_eq("b_addr", 64'(out_addr_b), 64'd4);
          check_eq("b_data", 64'(out_data_b), 64'(rf[4]));
          check_eq("b_last", 64'(out_last_b), 64'(CSUM == 0));
        end
        words_b++;
      end
    end
    check_eq("b_done_seen", 64'(seen_done), 64'd1);
    check_eq("b_first_valid", 64'(first_valid), 64'd3);
    check_eq("b_words", 64'(words_b), 64'(1 + CSUM));
    out_ready_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; start_b = 1'b0; out_ready_b = 1'b0;
    pc = $urandom();
    for (int k = 0; k < 32; k++) rf[k] = 32'(k * 3);

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_regaddr", 64'(regAddr), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_addr", 64'(out_addr), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'd0);

    // Full-rate scan of rf[k]=k*3 with PC at index 0
    run_scan(0, -1, -1, 1'b0, 1'b1);
    // Downstream stall on word 2
    run_scan(2, -1, -1, 1'b0, 1'b0);
    // Second start mid-scan must be ignored
    run_scan(0, 10, -1, 1'b0, 1'b1);
    // Reset during word 7, then a clean rescan from the first register
    run_scan(0, -1, 7, 1'b0, 1'b0);
    run_scan(0, -1, -1, 1'b1, 1'b1);

    for (int it = 0; it < 4; it++) begin
      pc = $urandom();
      for (int k = 0; k < 32; k++) rf[k] = $urandom();
      run_scan(1, int'($urandom_range(0, 40)), -1, 1'b1, 1'b0);
    end

    // All-ones registers: checksum word (when enabled) is PC+31
    pc = $urandom();
    for (int k = 0; k < 32; k++) rf[k] = 32'd1;
    run_scan(0, -1, -1, 1'b0, 1'b1);

    rf[4] = $urandom();
    run_single();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
